// File: rtl/tank_pkg.sv
// Shared constants, state encoding and quadrant helpers for the tank projectile logic.
package tank_pkg;

    localparam int unsigned NUM_ANGLES   = 45;
    localparam int unsigned FRAC_BITS    = 8;
    localparam int unsigned POS_W        = 10;
    localparam int unsigned ACC_W        = POS_W + FRAC_BITS;
    localparam int unsigned STEP_W       = 12;
    localparam int unsigned ANGLE_W      = 6;
    localparam int unsigned TRIG_W       = 16;
    localparam int unsigned SCREEN_X_MAX = 639;
    localparam int unsigned SCREEN_Y_MAX = 479;

    // Quadrant boundaries in direction-index units (8 degrees per step).
    localparam int unsigned Q1_LAST  = 11;
    localparam int unsigned Q2_FIRST = 12;
    localparam int unsigned Q2_LAST  = 22;
    localparam int unsigned Q3_FIRST = 23;
    localparam int unsigned Q3_LAST  = 33;
    localparam int unsigned Q4_FIRST = 34;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        FLY  = 2'd2
    } state_e;

    function automatic logic x_neg_of(input logic [ANGLE_W-1:0] angle);
        return (angle >= ANGLE_W'(Q2_FIRST)) && (angle <= ANGLE_W'(Q3_LAST));
    endfunction

    // Index 0 is horizontal, so it never moves up.
    function automatic logic y_up_of(input logic [ANGLE_W-1:0] angle);
        return (angle >= ANGLE_W'(1)) && (angle <= ANGLE_W'(Q2_LAST));
    endfunction

endpackage

// File: rtl/axis_step.sv
// One-axis fixed-point position update with reflection off the 0 and bound edges.
module axis_step
    import tank_pkg::*;
(
    input  logic [ACC_W-1:0]  acc_i,
    input  logic [STEP_W-1:0] step_i,
    input  logic              sub_i,
    input  logic [POS_W-1:0]  bound_i,
    output logic [ACC_W-1:0]  acc_o,
    output logic              sub_o
);

    logic [ACC_W:0] step_ext;
    logic [ACC_W:0] sum_ext;

    always_comb begin
        step_ext = (ACC_W+1)'(step_i);
        sum_ext  = sub_i ? ({1'b0, acc_i} - step_ext) : ({1'b0, acc_i} + step_ext);
        acc_o    = sum_ext[ACC_W-1:0];
        sub_o    = sub_i;
        // Extra top bit catches underflow when moving toward 0.
        if (sub_i && sum_ext[ACC_W]) begin
            acc_o = '0;
            sub_o = 1'b0;
        end else if (!sub_i && (sum_ext[ACC_W:FRAC_BITS] > (POS_W+1)'(bound_i))) begin
            acc_o = {bound_i, FRAC_BITS'(0)};
            sub_o = 1'b1;
        end
    end

endmodule

// File: rtl/bullet_motion.sv
// Single-bullet mover: accepts a fire request, then steps position once per frame tick
// using externally looked-up sin/cos magnitudes, bouncing off screen edges until expiry.
module bullet_motion
    import tank_pkg::*;
#(
    parameter int unsigned SPEED    = 2,
    parameter int unsigned LIFETIME = 300,
    parameter int unsigned X_MAX    = SCREEN_X_MAX,
    parameter int unsigned Y_MAX    = SCREEN_Y_MAX
) (
    input  logic               Clk,
    input  logic               Reset,
    input  logic               frame_clk,
    input  logic               fire,
    input  logic [POS_W-1:0]   fire_x,
    input  logic [POS_W-1:0]   fire_y,
    input  logic [ANGLE_W-1:0] fire_angle,
    output logic               fire_ack,
    output logic [ANGLE_W-1:0] angle_o,
    input  logic [TRIG_W-1:0]  sin_i,
    input  logic [TRIG_W-1:0]  cos_i,
    output logic               active,
    output logic [POS_W-1:0]   bullet_x,
    output logic [POS_W-1:0]   bullet_y
);

    localparam int unsigned LIFE_W = (LIFETIME < 2) ? 1 : $clog2(LIFETIME + 1);

    state_e              state_q, state_d;
    logic                frame_q;
    logic                tick_c;
    logic                fire_ack_q, fire_ack_d;
    logic                active_q, active_d;
    logic [ANGLE_W-1:0]  angle_q, angle_d;
    logic [ANGLE_W-1:0]  angle_eff_c;
    logic [ACC_W-1:0]    acc_x_q, acc_x_d;
    logic [ACC_W-1:0]    acc_y_q, acc_y_d;
    logic [STEP_W-1:0]   step_x_q, step_x_d;
    logic [STEP_W-1:0]   step_y_q, step_y_d;
    logic                x_neg_q, x_neg_d;
    logic                y_up_q, y_up_d;
    logic [LIFE_W-1:0]   life_q, life_d;
    logic [ACC_W-1:0]    nxt_x_c, nxt_y_c;
    logic                nxt_x_neg_c, nxt_y_up_c;
    logic                unused_trig_hi;

    assign tick_c         = frame_clk & ~frame_q;
    assign angle_eff_c    = (fire_angle > ANGLE_W'(NUM_ANGLES - 1)) ? '0 : fire_angle;
    assign unused_trig_hi = ^{sin_i[TRIG_W-1:9], cos_i[TRIG_W-1:9]};

    axis_step u_axis_x (
        .acc_i   (acc_x_q),
        .step_i  (step_x_q),
        .sub_i   (x_neg_q),
        .bound_i (POS_W'(X_MAX)),
        .acc_o   (nxt_x_c),
        .sub_o   (nxt_x_neg_c)
    );

    // Screen Y grows downward, so "up" subtracts.
    axis_step u_axis_y (
        .acc_i   (acc_y_q),
        .step_i  (step_y_q),
        .sub_i   (y_up_q),
        .bound_i (POS_W'(Y_MAX)),
        .acc_o   (nxt_y_c),
        .sub_o   (nxt_y_up_c)
    );

    always_comb begin
        state_d    = state_q;
        fire_ack_d = 1'b0;
        active_d   = active_q;
        angle_d    = angle_q;
        acc_x_d    = acc_x_q;
        acc_y_d    = acc_y_q;
        step_x_d   = step_x_q;
        step_y_d   = step_y_q;
        x_neg_d    = x_neg_q;
        y_up_d     = y_up_q;
        life_d     = life_q;

        case (state_q)
            IDLE: begin
                // A coincident tick is simply dropped here.
                if (fire) begin
                    acc_x_d    = {fire_x, FRAC_BITS'(0)};
                    acc_y_d    = {fire_y, FRAC_BITS'(0)};
                    angle_d    = angle_eff_c;
                    x_neg_d    = x_neg_of(angle_eff_c);
                    y_up_d     = y_up_of(angle_eff_c);
                    fire_ack_d = 1'b1;
                    state_d    = LOAD;
                end
            end
            LOAD: begin
                step_x_d = STEP_W'(SPEED) * STEP_W'(cos_i[8:0]);
                step_y_d = STEP_W'(SPEED) * STEP_W'(sin_i[8:0]);
                life_d   = LIFE_W'(LIFETIME);
                active_d = 1'b1;
                state_d  = FLY;
            end
            FLY: begin
                if (tick_c) begin
                    acc_x_d = nxt_x_c;
                    acc_y_d = nxt_y_c;
                    x_neg_d = nxt_x_neg_c;
                    y_up_d  = nxt_y_up_c;
                    life_d  = life_q - LIFE_W'(1);
                    if (life_q <= LIFE_W'(1)) begin
                        life_d   = '0;
                        active_d = 1'b0;
                        state_d  = IDLE;
                    end
                end
            end
            default: begin
                state_d  = IDLE;
                active_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q    <= IDLE;
            frame_q    <= 1'b0;
            fire_ack_q <= 1'b0;
            active_q   <= 1'b0;
            angle_q    <= '0;
            acc_x_q    <= '0;
            acc_y_q    <= '0;
            step_x_q   <= '0;
            step_y_q   <= '0;
            x_neg_q    <= 1'b0;
            y_up_q     <= 1'b0;
            life_q     <= '0;
        end else begin
            state_q    <= state_d;
            frame_q    <= frame_clk;
            fire_ack_q <= fire_ack_d;
            active_q   <= active_d;
            angle_q    <= angle_d;
            acc_x_q    <= acc_x_d;
            acc_y_q    <= acc_y_d;
            step_x_q   <= step_x_d;
            step_y_q   <= step_y_d;
            x_neg_q    <= x_neg_d;
            y_up_q     <= y_up_d;
            life_q     <= life_d;
        end
    end

    assign fire_ack = fire_ack_q;
    assign active   = active_q;
    assign angle_o  = angle_q;
    assign bullet_x = acc_x_q[ACC_W-1:FRAC_BITS];
    assign bullet_y = acc_y_q[ACC_W-1:FRAC_BITS];

endmodule
